case2_pipe: RTL and testbench

CASE2_PIPE -- requirements
Module: case2_pipe

---
 rtl/case2_pipe.sv | 264 ++++++++++++++++++++++++++
 tb/tb_case2_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/case2_pipe.sv
// -----------------------------------------------------------------------------
// case2_pipe
//
// Purpose
//   Two-stage pipelined evaluator of three per-bit boolean functions of four
//   operand lanes (a, b, c, d). Each result lane can be emitted bitwise
//   (mode=0) or reduced to a single bit in bit 0 (mode=1). Three saturating
//   counters accumulate the number of ones in every result beat that the
//   consumer accepts.
//
//   Per bit i (bitwise results):
//     x = (~a & ~b & ~(c & d)) | ((a | b) & ~c & ~d)
//     y = ((a & b) ^ c ^ d) & ((a & b) ^ (c | d))
//     z = (~(a & b) & c & d) ^ ((a | b) & ~(c | d))
//   Reduced results (mode=1): x[0] = |x, y[0] = &y, z[0] = ^z, upper bits 0.
//
// Ports
//   clk        in   1      sole clock, all state on the rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can take a beat this cycle
//   mode       in   1      sampled with the beat: 0 bitwise, 1 reduce
//   a,b,c,d    in   WIDTH  operand lanes
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer takes the result this cycle
//   x,y,z      out  WIDTH  result lanes
//   cnt_clr    in   1      synchronous clear of the ones counters
//   cnt_x/y/z  out  CNT_W  saturating ones counters
//
// Handshake rules (both ports): a beat moves when valid & ready are both high
// at a rising edge. A producer holding valid keeps its payload stable until
// the transfer. in_ready is a function of pipeline state and out_ready only;
// it never looks at in_valid. While out_valid & ~out_ready the output beat
// (out_valid, x, y, z) is frozen.
// -----------------------------------------------------------------------------
module case2_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_x,
  output logic [CNT_W-1:0] cnt_y,
  output logic [CNT_W-1:0] cnt_z
);

  // Popcount of one lane needs enough bits to hold WIDTH itself.
  localparam int PC_W  = $clog2(WIDTH + 1);
  // One extra bit over the wider operand so the add can never wrap before
  // the saturation compare.
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (sum > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end
    return sum[CNT_W-1:0];
  endfunction

  // Clear takes effect first, then a coinciding handshake adds its popcount,
  // so clear + handshake leaves exactly that beat's count.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic [PC_W-1:0]  inc,
                                                input logic             clr,
                                                input logic             hs);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cur;
    return hs ? sat_add(base, inc) : base;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Stage 1: pairwise operand terms plus the mode bit sampled with the beat.
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q,  s1_mode_d;
  logic [WIDTH-1:0] ab_and_q,   ab_and_d;
  logic [WIDTH-1:0] ab_or_q,    ab_or_d;
  logic [WIDTH-1:0] cd_and_q,   cd_and_d;
  logic [WIDTH-1:0] cd_or_q,    cd_or_d;
  logic [WIDTH-1:0] cd_xor_q,   cd_xor_d;

  // Stage 2: final result beat.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;

  // Ones counters.
  logic [CNT_W-1:0] cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0] cnt_y_q, cnt_y_d;
  logic [CNT_W-1:0] cnt_z_q, cnt_z_d;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s2_en;   // stage 2 may load this cycle
  logic s1_en;   // stage 1 may load this cycle
  logic out_hs;  // result beat is being consumed

  always_comb begin
    s2_en  = ~out_valid_q | out_ready;
    // Equivalent to ~s1_valid | ~out_valid | out_ready: stage 1 frees up
    // either because it is empty or because its beat moves into stage 2.
    s1_en  = ~s1_valid_q | s2_en;
    out_hs = out_valid_q & out_ready;
  end

  assign in_ready = s1_en;

  // ---------------------------------------------------------------------------
  // Stage 1 next state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    ab_and_d   = ab_and_q;
    ab_or_d    = ab_or_q;
    cd_and_d   = cd_and_q;
    cd_or_d    = cd_or_q;
    cd_xor_d   = cd_xor_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = mode;
        ab_and_d  = a & b;
        ab_or_d   = a | b;
        cd_and_d  = c & d;
        cd_or_d   = c | d;
        cd_xor_d  = c ^ d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 next state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] x_bw, y_bw, z_bw;
  logic [WIDTH-1:0] x_res, y_res, z_res;

  always_comb begin
    // ~a & ~b is ~(a | b); (a & b) ^ c ^ d is ab_and ^ (c ^ d).
    x_bw = (~ab_or_q & ~cd_and_q) | (ab_or_q & ~cd_or_q);
    y_bw = (ab_and_q ^ cd_xor_q) & (ab_and_q ^ cd_or_q);
    z_bw = (~ab_and_q & cd_and_q) ^ (ab_or_q & ~cd_or_q);

    if (s1_mode_q) begin
      x_res = WIDTH'(|x_bw);
      y_res = WIDTH'(&y_bw);
      z_res = WIDTH'(^z_bw);
    end else begin
      x_res = x_bw;
      y_res = y_bw;
      z_res = z_bw;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x_d = x_res;
        y_d = y_res;
        z_d = z_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters next state
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0] pc_x, pc_y, pc_z;

  always_comb begin
    pc_x    = popcount(x_q);
    pc_y    = popcount(y_q);
    pc_z    = popcount(z_q);
    cnt_x_d = cnt_next(cnt_x_q, pc_x, cnt_clr, out_hs);
    cnt_y_d = cnt_next(cnt_y_q, pc_y, cnt_clr, out_hs);
    cnt_z_d = cnt_next(cnt_z_q, pc_z, cnt_clr, out_hs);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      ab_and_q    <= '0;
      ab_or_q     <= '0;
      cd_and_q    <= '0;
      cd_or_q     <= '0;
      cd_xor_q    <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      cnt_z_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      ab_and_q    <= ab_and_d;
      ab_or_q     <= ab_or_d;
      cd_and_q    <= cd_and_d;
      cd_or_q     <= cd_or_d;
      cd_xor_q    <= cd_xor_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      cnt_z_q     <= cnt_z_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;
  assign cnt_x     = cnt_x_q;
  assign cnt_y     = cnt_y_q;
  assign cnt_z     = cnt_z_q;

endmodule

// File: tb/tb_case2_pipe.sv
// -----------------------------------------------------------------------------
// tb_case2_pipe
//
// Directed bench for case2_pipe. Two instances share all inputs: dut uses the
// default 16-bit counters, dut_s uses 4-bit counters so saturation shows up
// quickly. Inputs are driven and outputs sampled on the falling clock edge.
//
// Hand-derived reference values (WIDTH=8):
//   a=F0 b=CC c=AA d=00 bitwise : x=57 y=6A z=54  (ones 5,4,3)
//   same operands, reduce       : x=01 y=00 z=01  (ones 1,0,1)
//   a=88 b=88 c=00 d=00 bitwise : x=FF y=88 z=88  (ones 8,2,2)
//   b=c=d=0, any a, bitwise     : x=FF y=00 z=a
// -----------------------------------------------------------------------------
module tb_case2_pipe;

  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int CWS = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           in_valid, mode, out_ready, cnt_clr;
  logic [W-1:0]   a, b, c, d;
  logic           in_ready, out_valid;
  logic [W-1:0]   x, y, z;
  logic [CW-1:0]  cnt_x, cnt_y, cnt_z;
  logic           s_in_ready, s_out_valid;
  logic [W-1:0]   s_x, s_y, s_z;
  logic [CWS-1:0] s_cnt_x, s_cnt_y, s_cnt_z;

  case2_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y), .z(z),
    .cnt_clr(cnt_clr), .cnt_x(cnt_x), .cnt_y(cnt_y), .cnt_z(cnt_z)
  );

  case2_pipe #(.WIDTH(W), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .out_valid(s_out_valid), .out_ready(out_ready), .x(s_x), .y(s_y), .z(s_z),
    .cnt_clr(cnt_clr), .cnt_x(s_cnt_x), .cnt_y(s_cnt_y), .cnt_z(s_cnt_z)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_beat(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [W-1:0] vc, input logic [W-1:0] vd);
    in_valid = 1'b1;
    mode     = m;
    a        = va;
    b        = vb;
    c        = vc;
    d        = vd;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    mode     = 1'b0;
    a        = '0;
    b        = '0;
    c        = '0;
    d        = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [W-1:0] bp_a [5];
  int           sent;
  int           got;
  logic [W-1:0] exp_z;

  initial begin
    bp_a[0] = 8'h11; bp_a[1] = 8'h22; bp_a[2] = 8'h33; bp_a[3] = 8'h44; bp_a[4] = 8'h55;

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drive_idle();
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_cnt_x", 32'(cnt_x), 0);
    chk("rst_cnt_y", 32'(cnt_y), 0);
    chk("rst_cnt_z", 32'(cnt_z), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Bitwise beat, two-cycle latency
    drive_beat(1'b0, 8'hF0, 8'hCC, 8'hAA, 8'h00);
    step(); drive_idle();
    chk("bw_lat1_valid", 32'(out_valid), 0);
    step();
    chk("bw_valid", 32'(out_valid), 1);
    chk("bw_x", 32'(x), 'h57);
    chk("bw_y", 32'(y), 'h6A);
    chk("bw_z", 32'(z), 'h54);
    chk("bw_cnt_before_hs", 32'(cnt_x), 0);
    step();
    chk("bw_valid_drop", 32'(out_valid), 0);
    chk("bw_cnt_x", 32'(cnt_x), 5);
    chk("bw_cnt_y", 32'(cnt_y), 4);
    chk("bw_cnt_z", 32'(cnt_z), 3);

    // Reduce beat, same operands
    drive_beat(1'b1, 8'hF0, 8'hCC, 8'hAA, 8'h00);
    step(); drive_idle();
    step();
    chk("rd_x", 32'(x), 'h01);
    chk("rd_y", 32'(y), 'h00);
    chk("rd_z", 32'(z), 'h01);
    step();
    chk("rd_cnt_x", 32'(cnt_x), 6);
    chk("rd_cnt_y", 32'(cnt_y), 4);
    chk("rd_cnt_z", 32'(cnt_z), 4);

    // Clear coincident with the handshake of y=0x88
    drive_beat(1'b0, 8'h88, 8'h88, 8'h00, 8'h00);
    step(); drive_idle();
    step();
    chk("clr_x", 32'(x), 'hFF);
    chk("clr_y", 32'(y), 'h88);
    chk("clr_z", 32'(z), 'h88);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt_x", 32'(cnt_x), 8);
    chk("clr_cnt_y", 32'(cnt_y), 2);
    chk("clr_cnt_z", 32'(cnt_z), 2);
    chk("clr_s_cnt_y", 32'(s_cnt_y), 2);

    // Backpressure: 5 back-to-back beats, out_ready low for the first 4 edges
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      out_ready = (cyc >= 4);
      if (sent < 5) drive_beat(1'b0, bp_a[sent], 8'h00, 8'h00, 8'h00);
      else drive_idle();
      #1;
      if (cyc == 2) begin
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_accepted_before_stall", sent, 2);
      end
      if (cyc == 2 || cyc == 3) begin
        chk("bp_hold_valid", 32'(out_valid), 1);
        chk("bp_hold_z", 32'(z), 'h11);
      end
      if (out_valid && out_ready) begin
        exp_z = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk("bp_order_z", 32'(z), 32'(exp_z));
        chk("bp_x", 32'(x), 'hFF);
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(a);
        sent++;
      end
      step();
    end
    drive_idle();
    out_ready = 1'b1;
    chk("bp_all_emerged", got, 5);
    chk("bp_valid_drained", 32'(out_valid), 0);
    chk("bp_cnt_x", 32'(cnt_x), 48);
    chk("bp_cnt_y", 32'(cnt_y), 2);
    chk("bp_cnt_z", 32'(cnt_z), 16);
    chk("bp_s_cnt_x_sat", 32'(s_cnt_x), 15);
    chk("bp_s_cnt_z_sat", 32'(s_cnt_z), 15);

    // Mode change between consecutive beats
    drive_beat(1'b0, 8'hF0, 8'hCC, 8'hAA, 8'h00);
    step();
    drive_beat(1'b1, 8'hF0, 8'hCC, 8'hAA, 8'h00);
    step(); drive_idle();
    chk("mc_bw_x", 32'(x), 'h57);
    chk("mc_bw_y", 32'(y), 'h6A);
    chk("mc_bw_z", 32'(z), 'h54);
    step();
    chk("mc_rd_valid", 32'(out_valid), 1);
    chk("mc_rd_x", 32'(x), 'h01);
    chk("mc_rd_y", 32'(y), 'h00);
    chk("mc_rd_z", 32'(z), 'h01);
    step();
    chk("mc_valid_drop", 32'(out_valid), 0);
    chk("mc_cnt_x", 32'(cnt_x), 54);
    chk("mc_cnt_y", 32'(cnt_y), 6);
    chk("mc_cnt_z", 32'(cnt_z), 20);

    // Saturation: clear alone, then three beats of x=0xFF
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_clr_cnt_x", 32'(cnt_x), 0);
    chk("sat_clr_s_cnt_x", 32'(s_cnt_x), 0);
    chk("sat_clr_valid", 32'(out_valid), 0);
    drive_beat(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    step(); step(); step();
    drive_idle();
    chk("sat_s_cnt_x_8", 32'(s_cnt_x), 8);
    chk("sat_cnt_x_8", 32'(cnt_x), 8);
    step();
    chk("sat_s_cnt_x_15", 32'(s_cnt_x), 15);
    chk("sat_cnt_x_16", 32'(cnt_x), 16);
    step();
    chk("sat_s_cnt_x_stay", 32'(s_cnt_x), 15);
    chk("sat_cnt_x_24", 32'(cnt_x), 24);
    chk("sat_s_cnt_y", 32'(s_cnt_y), 0);

    // Reset with two beats in flight
    drive_beat(1'b0, 8'hF0, 8'hCC, 8'hAA, 8'h00);
    step();
    drive_beat(1'b0, 8'h88, 8'h88, 8'h00, 8'h00);
    step();
    drive_idle();
    chk("mid_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_x", 32'(x), 0);
    chk("mid_rst_cnt_x", 32'(cnt_x), 0);
    chk("mid_rst_cnt_y", 32'(cnt_y), 0);
    chk("mid_rst_cnt_z", 32'(cnt_z), 0);
    chk("mid_rst_s_cnt_x", 32'(s_cnt_x), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("mid_post_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      chk("mid_no_stale_valid", 32'(out_valid), 0);
      step();
    end
    chk("mid_post_cnt_x", 32'(cnt_x), 0);
    chk("mid_post_cnt_y", 32'(cnt_y), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
